mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the hart's single memory port between instruction fetch (IF) and the load/store unit (LSU). One transaction is in flight at a time: accept, issue, wait for response, route it back to the owner. LSU requests are preferred, with a starvation guard for fetch. Sits between the fetch/LSU stages and the memory or bus adapter.

## Interface
- `FETCH_STARVE_LIMIT`, 4: consecutive LSU grants allowed while IF is pending before IF is forced.
- `XLEN`, `isa_types::XLEN` (32): address and data width.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset. Single clock domain.
- `if_req_valid` in 1, `if_req_ready` out 1, `if_addr` in XLEN: fetch request (read, word).
- `if_flush` in 1: discard the response of any fetch currently in flight.
- `if_resp_valid` out 1, `if_resp_data` out XLEN: fetch response.
- `ls_req_valid` in 1, `ls_req_ready` out 1: LSU request handshake.
- `ls_addr` in XLEN, `ls_write` in 1, `ls_wdata` in XLEN, `ls_width` in `write_width_t`: LSU request fields.
- `ls_resp_valid` out 1, `ls_resp_data` out XLEN, `ls_resp_err` out 1: LSU response; `ls_resp_err` flags a misaligned access.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_addr` out XLEN, `mem_write` out 1, `mem_wdata` out XLEN, `mem_byte_en` out 4: memory request fields.
- `mem_resp_valid` in 1, `mem_resp_data` in XLEN: memory response; returned for writes too, as an acknowledge.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ERR.
- **IDLE**
  - Pick one requester:
    - LSU if `ls_req_valid`, unless `starve_cnt == FETCH_STARVE_LIMIT` and `if_req_valid`, in which case pick IF.
    - Otherwise IF if `if_req_valid`.
  - Only the picked requester sees ready = 1; the other sees 0.
  - On handshake:
    - Latch addr, write, byte_en, wdata and owner.
    - Misaligned LSU request → ERR. Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
    - Any other request → ISSUE.
- **ISSUE**
  - `mem_req_valid`=1 with the latched fields, held stable until `mem_req_ready`.
  - On `mem_req_ready` → WAIT.
- **WAIT**
  - On `mem_resp_valid` → IDLE. Route the response to the owner (see Timing).
- **ERR**
  - `ls_resp_valid`=1, `ls_resp_err`=1, `ls_resp_data`=0 for one cycle → IDLE. Memory is never touched.
- **Byte enables**
  - byte: `4'b0001 << addr[1:0]`.
  - halfword: `4'b0011 << {addr[1],1'b0}`.
  - word: `4'b1111`.
  - IF: always `4'b1111`.
  - Reads use the same mask.
- **Write-data lane replication**
  - byte: `{4{wdata[7:0]}}`.
  - halfword: `{2{wdata[15:0]}}`.
  - word: unchanged.
- `mem_addr` = latched addr, unmodified (byte address).
- **Starvation counter `starve_cnt`**
  - +1 on each LSU grant while `if_req_valid`=1, saturating at the limit.
  - Cleared on every IF grant.
  - Unchanged on an LSU grant with IF idle.
- **Flush**
  - `if_flush` while owner=IF and state is ISSUE or WAIT sets `drop`.
  - The issue still completes, but `if_resp_valid` is suppressed for that response.
  - `drop` is cleared on entering IDLE.
  - `if_flush` in IDLE has no effect.
- `mem_resp_valid` in IDLE, ISSUE or ERR is ignored.
- **Reset values (asynchronous)**
  - State IDLE; `starve_cnt`=0; `drop`=0.
  - All valid/ready outputs 0.
  - Data outputs 0.

## Timing
- Request accepted at cycle N; `mem_req_valid` asserted in N+1.
- `if_req_ready`/`ls_req_ready` are combinational from the IDLE state and the valids. No valid→ready→valid loop: requesters must not gate valid on ready.
- Responses pass through combinationally in the cycle `mem_resp_valid`=1: `*_resp_data` = `mem_resp_data`. The next request can be accepted one cycle later.
- Minimum turnaround, with `mem_req_ready` at N+1 and the memory response at N+2: the next acceptance is at N+3.
- Misaligned request: `ls_resp_valid` at N+1; next acceptance at N+2.
- Reset asserted mid-transaction: everything is abandoned immediately. A late memory response after release lands in IDLE and is ignored.
- Simultaneous `if_flush` and `mem_resp_valid` in WAIT: the response is dropped.

## Structure
- Add to `isa_types`:
  - `mem_owner_t` (OWNER_IF, OWNER_LS).
  - `arb_state_t`.
  - Function `byte_enable(write_width_t, logic [1:0])`.
  - Function `misaligned(write_width_t, logic [1:0])`.
- One combinational sub-module, `mem_lane_align`: computes byte_en, the replicated wdata and the misaligned flag from width/addr/wdata.

## Test plan
- **Lone fetch:** IF addr 0x100, `mem_req_ready`=1, response 0x00000013 next cycle.
  - Expect: `mem_byte_en`=1111, `if_resp_valid`=1 with 0x00000013, LSU outputs idle.
- **Byte store:** addr 0x203, wdata 0xAB.
  - Expect: `mem_byte_en`=1000, `mem_wdata`=0xABABABAB, `mem_write`=1, `ls_resp_valid` on the ack.
- **Misaligned word load:** addr 0x202.
  - Expect: `ls_resp_err`=1 at N+1, `mem_req_valid` never asserted.
- **Starvation guard:** IF and LSU both valid continuously.
  - Expect grant order LS, LS, LS, LS, IF, LS, …, with `starve_cnt` back to 0 after each IF grant.
- **Flush in WAIT:** `if_flush` asserted while the fetch is in WAIT.
  - Expect: the memory response is consumed, `if_resp_valid` stays 0, the next request is accepted normally.
- **Reset in ISSUE:** reset with `mem_req_ready`=0, then release, then inject a stray `mem_resp_valid`.
  - Expect: all outputs 0 during reset, no resp valids afterwards, IDLE accepts new requests.

Source files
------------

// File: rtl/isa_types.sv
// isa_types: shared ISA-level types for the hart.
// Holds XLEN, the LSU access width encoding, and the memory-port arbiter's
// owner/state types plus the lane helpers used by mem_lane_align.
package isa_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } write_width_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } mem_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_ERR
  } arb_state_t;

  // Byte lanes touched by an access of width w at byte offset a.
  // The unused encoding is treated as a word access.
  function automatic logic [3:0] byte_enable(write_width_t w, logic [1:0] a);
    case (w)
      WIDTH_BYTE: return 4'b0001 << a;
      WIDTH_HALF: return 4'b0011 << {a[1], 1'b0};
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(write_width_t w, logic [1:0] a);
    case (w)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return a[0];
      default:    return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// mem_lane_align: combinational lane formatting for LSU memory requests.
//   width_i      access width
//   addr_lo_i    byte offset within the word
//   wdata_i      raw store data (low bytes significant for byte/half)
//   byte_en_o    byte-lane enables
//   wdata_o      store data replicated across all lanes
//   misaligned_o access not naturally aligned
module mem_lane_align
  import isa_types::*;
(
  input  write_width_t      width_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [3:0]        byte_en_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              misaligned_o
);

  always_comb begin
    byte_en_o    = byte_enable(width_i, addr_lo_i);
    misaligned_o = misaligned(width_i, addr_lo_i);
    case (width_i)
      WIDTH_BYTE: wdata_o = {4{wdata_i[7:0]}};
      WIDTH_HALF: wdata_o = {2{wdata_i[15:0]}};
      default:    wdata_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// and the LSU, one transaction in flight at a time. LSU is preferred; after
// FETCH_STARVE_LIMIT consecutive LSU grants with fetch pending, fetch wins.
//   if_req_*  / if_resp_*  fetch request (word read) and response
//   if_flush               drop the response of an in-flight fetch
//   ls_req_*  / ls_*       LSU request fields; ls_resp_err = misaligned access
//   mem_req_* / mem_*      memory request, mem_resp_* response (also write ack)
module mem_port_arbiter #(
  parameter int unsigned FETCH_STARVE_LIMIT = 4,
  parameter int unsigned XLEN               = isa_types::XLEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [XLEN-1:0]         if_addr,
  input  logic                    if_flush,
  output logic                    if_resp_valid,
  output logic [XLEN-1:0]         if_resp_data,
  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic [XLEN-1:0]         ls_addr,
  input  logic                    ls_write,
  input  logic [XLEN-1:0]         ls_wdata,
  input  isa_types::write_width_t ls_width,
  output logic                    ls_resp_valid,
  output logic [XLEN-1:0]         ls_resp_data,
  output logic                    ls_resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [XLEN-1:0]         mem_addr,
  output logic                    mem_write,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [3:0]              mem_byte_en,
  input  logic                    mem_resp_valid,
  input  logic [XLEN-1:0]         mem_resp_data
);
  import isa_types::*;

  localparam int unsigned SW = (FETCH_STARVE_LIMIT > 0) ? $clog2(FETCH_STARVE_LIMIT + 1) : 1;

  arb_state_t      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            drop_q, drop_d;
  mem_owner_t      owner_q, owner_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            write_q, write_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;

  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic            lane_mis;
  logic            at_limit;
  logic            pick_ls;

  mem_lane_align u_align (
    .width_i      (ls_width),
    .addr_lo_i    (ls_addr[1:0]),
    .wdata_i      (ls_wdata),
    .byte_en_o    (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_mis)
  );

  assign at_limit = (starve_q == SW'(FETCH_STARVE_LIMIT));
  assign pick_ls  = ls_req_valid && !(at_limit && if_req_valid);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    be_d     = be_q;

    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    if_resp_valid = 1'b0;
    if_resp_data  = '0;
    ls_resp_valid = 1'b0;
    ls_resp_data  = '0;
    ls_resp_err   = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_write     = 1'b0;
    mem_wdata     = '0;
    mem_byte_en   = '0;

    case (state_q)
      ARB_IDLE: begin
        // Readies are gated by rst_n so nothing looks acceptable while the
        // state register is held in reset.
        ls_req_ready = rst_n && pick_ls;
        if_req_ready = rst_n && !pick_ls && if_req_valid;
        if (ls_req_ready) begin
          owner_d = OWNER_LS;
          addr_d  = ls_addr;
          write_d = ls_write;
          wdata_d = lane_wdata;
          be_d    = lane_be;
          state_d = lane_mis ? ARB_ERR : ARB_ISSUE;
          if (if_req_valid && !at_limit) starve_d = starve_q + 1'b1;
        end else if (if_req_ready) begin
          owner_d  = OWNER_IF;
          addr_d   = if_addr;
          write_d  = 1'b0;
          wdata_d  = '0;
          be_d     = 4'b1111;
          state_d  = ARB_ISSUE;
          starve_d = '0;
        end
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_addr      = addr_q;
        mem_write     = write_q;
        mem_wdata     = wdata_q;
        mem_byte_en   = be_q;
        if (mem_req_ready) state_d = ARB_WAIT;
        if (if_flush && owner_q == OWNER_IF) drop_d = 1'b1;
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ARB_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWNER_LS) begin
            ls_resp_valid = 1'b1;
            ls_resp_data  = mem_resp_data;
          end else if (!drop_q && !if_flush) begin
            // A flush arriving with the response still kills it.
            if_resp_valid = 1'b1;
            if_resp_data  = mem_resp_data;
          end
        end else if (if_flush && owner_q == OWNER_IF) begin
          drop_d = 1'b1;
        end
      end
      ARB_ERR: begin
        ls_resp_valid = 1'b1;
        ls_resp_err   = 1'b1;
        state_d       = ARB_IDLE;
        drop_d        = 1'b0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
      owner_q  <= OWNER_IF;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

endmodule
